// File: rtl/modbus_tx_sequencer.sv
// Builds one Modbus RTU response frame, appends a bit-serial CRC-16/MODBUS and feeds the bytes to uart_byte_tx.
// After the last byte it holds the 3.5-character silence, then pulses done (and err if a byte timed out).
module modbus_tx_sequencer #(
  parameter int         CLK_FREQ   = 50000000,
  parameter int         BAUD_RATE  = 115200,
  parameter logic [7:0] SLAVE_ADDR = 8'h01
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req,
  input  logic [1:0]  rsp_type,
  input  logic [7:0]  func_code,
  input  logic [15:0] reg_addr,
  input  logic [15:0] reg_data,
  input  logic [7:0]  exc_code,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  localparam int BIT_CYC = CLK_FREQ / BAUD_RATE;
  localparam int GAP_CYC = BIT_CYC * 39;
  localparam int TO_CYC  = BIT_CYC * 16;
  localparam int CW      = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC);
  localparam logic [CW-1:0] TO_END  = CW'(TO_CYC - 1);

  typedef enum logic [2:0] {IDLE, CRC, LOAD, WAIT, GAP} state_t;

  state_t          state, state_nxt;
  logic [7:0]      frame [8];
  logic [3:0]      len;
  logic [3:0]      len_m2;
  logic [2:0]      idx;
  logic [5:0]      bit_cnt;
  logic [15:0]     crc;
  logic [15:0]     crc_nxt;
  logic [CW-1:0]   cnt;
  logic            err_flag;
  logic            cur_bit;
  logic            crc_end;
  logic            last_byte;
  logic            timeout;
  logic            gap_end;

  assign len_m2    = len - 4'd2;
  assign cur_bit   = frame[bit_cnt[5:3]][bit_cnt[2:0]];
  assign crc_nxt   = {1'b0, crc[15:1]} ^ ((crc[0] ^ cur_bit) ? 16'hA001 : 16'h0000);
  assign crc_end   = (bit_cnt == {len_m2[2:0], 3'b000});
  assign last_byte = ({1'b0, idx} == (len - 4'd1));
  assign timeout   = (cnt == TO_END);
  assign gap_end   = (cnt == GAP_END);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    tx_start  = 1'b0;
    case (state)
      IDLE: if (req) state_nxt = CRC;
      CRC: begin
        busy = 1'b1;
        if (crc_end) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        tx_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (tx_done)      state_nxt = last_byte ? GAP : LOAD;
        else if (timeout) state_nxt = GAP;
      end
      GAP: begin
        if (gap_end) begin
          done      = 1'b1;
          err       = err_flag;
          state_nxt = IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < 8; k++) frame[k] <= 8'h00;
      len      <= 4'd5;
      idx      <= 3'd0;
      bit_cnt  <= 6'd0;
      crc      <= 16'hFFFF;
      cnt      <= '0;
      err_flag <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            crc      <= 16'hFFFF;
            idx      <= 3'd0;
            bit_cnt  <= 6'd0;
            err_flag <= 1'b0;
            frame[0] <= SLAVE_ADDR;
            case (rsp_type)
              2'd0: begin
                frame[1] <= 8'h03;
                frame[2] <= 8'h02;
                frame[3] <= reg_data[15:8];
                frame[4] <= reg_data[7:0];
                len      <= 4'd7;
              end
              2'd1: begin
                frame[1] <= 8'h06;
                frame[2] <= reg_addr[15:8];
                frame[3] <= reg_addr[7:0];
                frame[4] <= reg_data[15:8];
                frame[5] <= reg_data[7:0];
                len      <= 4'd8;
              end
              default: begin
                frame[1] <= func_code | 8'h80;
                frame[2] <= exc_code;
                len      <= 4'd5;
              end
            endcase
          end
        end
        CRC: begin
          // one message bit per cycle, LSB first; the two tail slots receive the CRC
          if (crc_end) begin
            frame[len_m2[2:0]]        <= crc[7:0];
            frame[len_m2[2:0] + 3'd1] <= crc[15:8];
            tx_data                   <= frame[0];
          end else begin
            crc     <= crc_nxt;
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        LOAD: cnt <= '0;
        WAIT: begin
          if (tx_done) begin
            cnt <= '0;
            if (!last_byte) begin
              idx     <= idx + 3'd1;
              tx_data <= frame[idx + 3'd1];
            end
          end else if (timeout) begin
            cnt      <= '0;
            err_flag <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: if (!gap_end) cnt <= cnt + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_tx_sequencer.sv
// Scoreboard bench for modbus_tx_sequencer: a UART responder answers tx_start with tx_done,
// sent bytes are popped from an expected-byte queue, and frame timing is checked against cycle stamps.
module tb_modbus_tx_sequencer;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 500000;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;
  localparam int GAP_CYC  = BIT_CYC * 39;
  localparam int TO_CYC   = BIT_CYC * 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req;
  logic [1:0]  rsp_type;
  logic [7:0]  func_code;
  logic [15:0] reg_addr;
  logic [15:0] reg_data;
  logic [7:0]  exc_code;
  logic        busy, done, err, tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_pulse = 1'b0;
  logic        spur = 1'b0;

  assign tx_done = resp_pulse | spur;

  modbus_tx_sequencer #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .SLAVE_ADDR(8'h01)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .req(req), .rsp_type(rsp_type), .func_code(func_code),
    .reg_addr(reg_addr), .reg_data(reg_data), .exc_code(exc_code), .busy(busy), .done(done),
    .err(err), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] exp_q [$];

  int req_cyc = 0, exp_first_lat = 0, bidx = 0;
  int resp_cnt = -1, resp_delay = 3, drop_at = 0;
  int last_resp_cyc = 0, last_start_cyc = 0;
  int done_cnt = 0, done_cyc = 0, done_target = 0;
  logic done_err = 1'b0;
  logic [7:0] last_byte = 8'h00;

  localparam logic [63:0] F_WRITE = 64'h01_06_00_01_00_05_18_09;
  localparam logic [63:0] F_READ  = 64'h00_01_03_02_00_01_79_84;
  localparam logic [63:0] F_EXC   = 64'h00_00_00_01_83_02_C0_F1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk_in) cyc <= cyc + 1;

  // UART responder plus output monitor
  always @(negedge clk_in) begin
    resp_pulse = 1'b0;
    if (resp_cnt == 0) begin
      resp_pulse = 1'b1;
      last_resp_cyc = cyc;
      check_val("tx_data_hold", 32'(tx_data), 32'(last_byte));
    end
    if (resp_cnt >= 0) resp_cnt--;
    if (tx_start) begin
      if (exp_q.size() == 0) check_val("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
      else                   check_val("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      if (bidx == 0) check_val("first_start_lat", 32'(cyc - req_cyc), 32'(exp_first_lat));
      else           check_val("next_start_lat", 32'(cyc - last_resp_cyc), 32'd1);
      bidx++;
      last_start_cyc = cyc;
      last_byte = tx_data;
      if (drop_at == 0 || bidx < drop_at) resp_cnt = resp_delay - 1;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
      check_val("busy_in_done", 32'(busy), 32'd0);
    end
  end

  task automatic push_frame(input logic [63:0] f, input int n, input int m);
    for (int k = 0; k < m; k++) exp_q.push_back(f[8*(n-1-k) +: 8]);
  endtask

  task automatic issue(input logic [1:0] rt, input logic [7:0] fc, input logic [15:0] ad,
                       input logic [15:0] dt, input logic [7:0] ex, input int n, input bit hold);
    @(negedge clk_in);
    rsp_type = rt; func_code = fc; reg_addr = ad; reg_data = dt; exc_code = ex;
    req = 1'b1;
    req_cyc = cyc;
    bidx = 0;
    exp_first_lat = 8*(n-2) + 2;
    @(negedge clk_in);
    if (!hold) req = 1'b0;
    check_val("busy_after_accept", 32'(busy), 32'd1);
    rsp_type = rt ^ 2'b01; func_code = 8'hAA; reg_addr = 16'hDEAD; reg_data = 16'hBEEF; exc_code = 8'h55;
  endtask

  task automatic wait_done(input int target);
    int budget = 20000;
    while (done_cnt < target && budget > 0) begin
      @(negedge clk_in);
      budget--;
    end
    if (done_cnt < target) check_val("done_wait_expired", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    rst_in = 1'b1; req = 1'b0; rsp_type = 2'd0; func_code = 8'h00;
    reg_addr = 16'h0000; reg_data = 16'h0000; exc_code = 8'h00;
    repeat (3) @(negedge clk_in);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_tx_start", 32'(tx_start), 32'd0);
    check_val("rst_tx_data", 32'(tx_data), 32'd0);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // write echo
    resp_delay = 3;
    push_frame(F_WRITE, 8, 8);
    issue(2'd1, 8'h06, 16'h0001, 16'h0005, 8'h00, 8, 1'b0);
    done_target++; wait_done(done_target);
    check_val("w_gap_lat", 32'(done_cyc - last_resp_cyc), 32'(GAP_CYC + 1));
    check_val("w_err", 32'(done_err), 32'd0);
    check_val("w_q_empty", 32'(exp_q.size()), 32'd0);

    // read reply
    resp_delay = 7;
    push_frame(F_READ, 7, 7);
    issue(2'd0, 8'h03, 16'h0010, 16'h0001, 8'h00, 7, 1'b0);
    done_target++; wait_done(done_target);
    check_val("r_gap_lat", 32'(done_cyc - last_resp_cyc), 32'(GAP_CYC + 1));
    check_val("r_err", 32'(done_err), 32'd0);
    check_val("r_q_empty", 32'(exp_q.size()), 32'd0);

    // exception, tx_done the very next cycle
    resp_delay = 1;
    push_frame(F_EXC, 5, 5);
    issue(2'd2, 8'h03, 16'h0000, 16'h0000, 8'h02, 5, 1'b0);
    done_target++; wait_done(done_target);
    check_val("e_gap_lat", 32'(done_cyc - last_resp_cyc), 32'(GAP_CYC + 1));
    check_val("e_err", 32'(done_err), 32'd0);
    check_val("e_q_empty", 32'(exp_q.size()), 32'd0);

    // tx_done never arrives for the third byte
    resp_delay = 4;
    drop_at = 3;
    push_frame(F_WRITE, 8, 3);
    issue(2'd1, 8'h06, 16'h0001, 16'h0005, 8'h00, 8, 1'b0);
    done_target++; wait_done(done_target);
    check_val("to_lat", 32'(done_cyc - last_start_cyc), 32'(TO_CYC + 1 + GAP_CYC));
    check_val("to_err", 32'(done_err), 32'd1);
    check_val("to_q_empty", 32'(exp_q.size()), 32'd0);

    // reset while waiting on the fourth byte, then a clean frame
    drop_at = 4;
    push_frame(F_WRITE, 8, 4);
    issue(2'd1, 8'h06, 16'h0001, 16'h0005, 8'h00, 8, 1'b0);
    begin
      int budget = 2000;
      while (bidx < 4 && budget > 0) begin
        @(negedge clk_in);
        budget--;
      end
      if (bidx < 4) check_val("abort_wait_expired", 32'(bidx), 32'd4);
    end
    repeat (5) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_tx_start", 32'(tx_start), 32'd0);
    check_val("abort_tx_data", 32'(tx_data), 32'd0);
    check_val("abort_q_empty", 32'(exp_q.size()), 32'd0);
    drop_at = 0;
    resp_delay = 5;
    push_frame(F_WRITE, 8, 8);
    issue(2'd1, 8'h06, 16'h0001, 16'h0005, 8'h00, 8, 1'b0);
    done_target++; wait_done(done_target);
    check_val("restart_err", 32'(done_err), 32'd0);
    check_val("restart_gap_lat", 32'(done_cyc - last_resp_cyc), 32'(GAP_CYC + 1));
    check_val("restart_q_empty", 32'(exp_q.size()), 32'd0);

    // spurious tx_done in IDLE, then req held high across two frames
    @(negedge clk_in); spur = 1'b1;
    @(negedge clk_in); spur = 1'b0;
    repeat (3) @(negedge clk_in);
    check_val("spur_idle_busy", 32'(busy), 32'd0);
    check_val("spur_idle_start", 32'(tx_start), 32'd0);
    push_frame(F_READ, 7, 7);
    push_frame(F_EXC, 5, 5);
    issue(2'd0, 8'h03, 16'h0000, 16'h0001, 8'h00, 7, 1'b1);
    rsp_type = 2'd3; func_code = 8'h03; exc_code = 8'h02;
    repeat (4) @(negedge clk_in);
    spur = 1'b1;
    @(negedge clk_in); spur = 1'b0;
    done_target++; wait_done(done_target);
    check_val("b2b_gap_lat", 32'(done_cyc - last_resp_cyc), 32'(GAP_CYC + 1));
    req_cyc = done_cyc + 1;
    exp_first_lat = 8*3 + 2;
    bidx = 0;
    while (cyc < done_cyc + 2) @(negedge clk_in);
    check_val("b2b_busy", 32'(busy), 32'd1);
    req = 1'b0;
    done_target++; wait_done(done_target);
    check_val("b2b2_gap_lat", 32'(done_cyc - last_resp_cyc), 32'(GAP_CYC + 1));
    check_val("b2b2_err", 32'(done_err), 32'd0);
    check_val("b2b_q_empty", 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clk_in);
    check_val("final_idle_busy", 32'(busy), 32'd0);
    check_val("final_done_cnt", 32'(done_cnt), 32'(done_target));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
